gb_cpu_alu16_sequencer: RTL and testbench
=========================================

// Module: gb_cpu_alu16_sequencer
// PURPOSE
//  Runs 16-bit arithmetic micro-ops (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) on the shared 8-bit ALU.
//  Each op is two ALU passes: low byte, then high byte with carry chained.
//  Sits between the decode/control unit (request side) and the ALU port (alu_instruction_t).
//  Requests ALU ownership from the ALU arbiter before each pass.
// PARAMETERS
//  ALU_LAT  1  cycles from ALU issue to valid alu_result/alu_flags (1 = combinational, sampled at issue edge; 2 = registered ALU)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   sequencer can accept (high only in IDLE)
//  req_op         in   2   alu16_op_t: ADD16, INC16, DEC16, ADD_SP_E8
//  req_a          in   16  operand A (HL or SP or rr)
//  req_b          in   16  operand B (rr; low byte = e8 for ADD_SP_E8; ignored for INC16/DEC16)
//  req_flags      in   4   current {Z,N,H,C}
//  resp_valid     out  1   result available
//  resp_ready     in   1   consumer takes result
//  resp_result    out  16  16-bit result
//  resp_flags     out  4   new {Z,N,H,C}
//  resp_flag_we   out  1   1 = write resp_flags to F; 0 = leave F untouched
//  alu_req        out  1   request ALU for current pass
//  alu_gnt        in   1   arbiter grants ALU this cycle
//  alu_instr      out  -   alu_instruction_t {operand_a, operand_b, opcode}
//  alu_carry_in   out  1   carry/borrow into ALU ADD/SUB
//  alu_result     in   8   ALU byte result
//  alu_flags      in   4   ALU {Z,N,H,C}
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; alu_req=0; resp_result=0; resp_flags=0; resp_flag_we=0; alu_instr, alu_carry_in =0.
//  FSM: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: accept on req_valid&req_ready; latch op/operands/flags.
//   LO: alu_req=1; drive low bytes. Pass completes ALU_LAT cycles after the first alu_gnt cycle.
//   HI: same for high bytes.
//   DONE: resp_valid=1, outputs stable until resp_ready; on handshake -> IDLE.
//  Issue rule: alu_instr/alu_carry_in held constant while alu_req=1. No advance without alu_gnt. Gnt dropped mid-wait (ALU_LAT=2) is ignored once issued.
//  Latency (gnt always 1, ALU_LAT=1): accept edge 0; resp_valid from cycle 3. Each extra gnt-low cycle adds 1.
//  Pass encoding:
//   ADD16: LO ADD a[7:0]+b[7:0], cin=0. HI ADD a[15:8]+b[15:8], cin=C_lo.
//   INC16: LO ADD a_lo+1, cin=0. HI ADD a_hi+0, cin=C_lo.
//   DEC16: LO SUB a_lo-1, cin=0. HI SUB a_hi-0, borrow-in=C_lo.
//   ADD_SP_E8: LO ADD sp_lo+e8, cin=0. HI ADD sp_hi+(e8[7]?8'hFF:8'h00), cin=C_lo.
//  Flags:
//   ADD16: Z=req_flags.Z, N=0, H=H_hi (bit 11), C=C_hi (bit 15), flag_we=1.
//   ADD_SP_E8: Z=0, N=0, H=H_lo (bit 3), C=C_lo (bit 7), flag_we=1.
//   INC16/DEC16: flag_we=0, resp_flags=req_flags.
//  Wrap: results are mod 2^16 (FFFF+1=0000, 0000-1=FFFF).
//  req_valid in non-IDLE is ignored: req_ready=0, no latch.
//  Async reset mid-op aborts immediately to IDLE: alu_req=0, no response.
// CONFIGURATION
//  GB_CPU_IDU_BYPASS_EN defined:
//   INC16/DEC16 use an internal 16-bit incrementer: IDLE -> DONE directly, resp_valid the cycle after accept.
//   alu_req never asserted for them.
//  Not defined: INC16/DEC16 take the two-pass ALU path above.
//  Result and flags are identical either way.
// STRUCTURE
//  gb_cpu_common_pkg additions:
//   alu16_op_t enum.
//   alu16_state_t {IDLE,LO,HI,DONE}.
//   flag bit index constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0.
//  Reuses alu_instruction_t and alu_opcode_t (ADD, SUB).
//  Single module, no sub-modules. Pass-wait counter is only present when ALU_LAT>1.
// TESTING
//  ADD16 a=0x0FFF b=0x0001 flags=4'b1000 -> result 0x1000, flags {Z1,N0,H1,C0}, flag_we=1, resp_valid at cycle 3.
//  ADD16 a=0xFFFF b=0x0001 -> 0x0000, {Z=req Z,N0,H1,C1}. ADD16 a=0x8000 b=0x8000 -> 0x0000, H0 C1.
//  DEC16 a=0x0000 -> 0xFFFF, flag_we=0. INC16 a=0x00FF -> 0x0100. Repeat both with GB_CPU_IDU_BYPASS_EN: resp_valid at cycle 1, alu_req never high.
//  ADD_SP_E8 sp=0xFFF8 e8=0x08 -> 0x0000, {0,0,1,1}. sp=0x0005 e8=0xFE -> 0x0003, {0,0,1,1}.
//  alu_gnt low 3 cycles in LO, and resp_ready low 2 cycles in DONE -> alu_instr stable while waiting, result unchanged, latency +5.
//  reset asserted during HI -> next cycle IDLE, req_ready=1, alu_req=0, resp_valid=0. ALU_LAT=2 run of the ADD16 case -> resp_valid at cycle 5.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: ALU port encoding plus the 16-bit sequencer op/state enums.
package gb_cpu_common_pkg;

  // Flag bit positions inside a {Z,N,H,C} nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    ADC = 4'h1,
    SUB = 4'h2,
    SBC = 4'h3
  } alu_opcode_t;

  typedef struct packed {
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    alu_opcode_t opcode;
  } alu_instruction_t;

  typedef enum logic [1:0] {
    ADD16     = 2'd0,
    INC16     = 2'd1,
    DEC16     = 2'd2,
    ADD_SP_E8 = 2'd3
  } alu16_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } alu16_state_t;

endpackage

// File: rtl/gb_cpu_alu16_sequencer.sv
// 16-bit arithmetic micro-op sequencer: two byte passes on the shared 8-bit ALU,
// carry chained from the low pass into the high pass.
// Optional: GB_CPU_IDU_BYPASS_EN routes INC16/DEC16 through an internal incrementer.
module gb_cpu_alu16_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  alu16_op_t        req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [3:0]       req_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [15:0]      resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_flag_we,
  output logic             alu_req,
  input  logic             alu_gnt,
  output alu_instruction_t alu_instr,
  output logic             alu_carry_in,
  input  logic [7:0]       alu_result,
  input  logic [3:0]       alu_flags
);

  alu16_state_t state_q, state_d;
  alu16_op_t    op_q, op_d;
  logic [15:0]  a_q, a_d, b_q, b_d;
  logic [3:0]   flags_q, flags_d;
  logic [7:0]   lo_q, lo_d;
  logic         c_lo_q, c_lo_d, h_lo_q, h_lo_d;
  logic [15:0]  result_q, result_d;
  logic [3:0]   rflags_q, rflags_d;
  logic         we_q, we_d;
  logic         in_pass, pass_done;
  logic [7:0]   hi_b;

  // Only H and C of the ALU flags feed the 16-bit result
  logic unused_alu_zn;
  assign unused_alu_zn = alu_flags[FLAG_Z] ^ alu_flags[FLAG_N];

  assign in_pass = (state_q == LO) || (state_q == HI);

  if (ALU_LAT > 1) begin : g_wait
    localparam int unsigned CntW = $clog2(ALU_LAT);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count from the issuing grant; later grant changes do not matter
    always_comb begin
      cnt_d = cnt_q;
      if (in_pass) begin
        if (cnt_q == '0) begin
          if (alu_gnt) cnt_d = CntW'(1);
        end else if (cnt_q == CntW'(ALU_LAT - 1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Pass-wait counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign pass_done = in_pass && (cnt_q == CntW'(ALU_LAT - 1));
  end else begin : g_no_wait
    // Combinational ALU: result is sampled on the granting edge
    assign pass_done = in_pass && alu_gnt;
  end

  // High-byte operand B: sign extension for e8, zero for INC/DEC carry propagation
  always_comb begin
    unique case (op_q)
      ADD16:     hi_b = b_q[15:8];
      ADD_SP_E8: hi_b = {8{b_q[7]}};
      default:   hi_b = 8'h00;
    endcase
  end

  // Next-state, datapath capture and handshake/ALU outputs
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    flags_d      = flags_q;
    lo_d         = lo_q;
    c_lo_d       = c_lo_q;
    h_lo_d       = h_lo_q;
    result_d     = result_q;
    rflags_d     = rflags_q;
    we_d         = we_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    alu_req      = 1'b0;
    alu_instr    = '0;
    alu_carry_in = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          flags_d = req_flags;
          state_d = LO;
`ifdef GB_CPU_IDU_BYPASS_EN
          if (req_op == INC16 || req_op == DEC16) begin
            result_d = (req_op == INC16) ? req_a + 16'd1 : req_a - 16'd1;
            rflags_d = req_flags;
            we_d     = 1'b0;
            state_d  = DONE;
          end
`endif
        end
      end
      LO: begin
        alu_req             = 1'b1;
        alu_instr.operand_a = a_q[7:0];
        alu_instr.operand_b = (op_q == INC16 || op_q == DEC16) ? 8'h01 : b_q[7:0];
        alu_instr.opcode    = (op_q == DEC16) ? SUB : ADD;
        if (pass_done) begin
          lo_d    = alu_result;
          c_lo_d  = alu_flags[FLAG_C];
          h_lo_d  = alu_flags[FLAG_H];
          state_d = HI;
        end
      end
      HI: begin
        alu_req             = 1'b1;
        alu_instr.operand_a = a_q[15:8];
        alu_instr.operand_b = hi_b;
        alu_instr.opcode    = (op_q == DEC16) ? SUB : ADD;
        alu_carry_in        = c_lo_q;
        if (pass_done) begin
          result_d = {alu_result, lo_q};
          state_d  = DONE;
          unique case (op_q)
            ADD16: begin
              rflags_d         = '0;
              rflags_d[FLAG_Z] = flags_q[FLAG_Z];
              rflags_d[FLAG_H] = alu_flags[FLAG_H];
              rflags_d[FLAG_C] = alu_flags[FLAG_C];
              we_d             = 1'b1;
            end
            ADD_SP_E8: begin
              // SP+e8 flags come from the low byte only
              rflags_d         = '0;
              rflags_d[FLAG_H] = h_lo_q;
              rflags_d[FLAG_C] = c_lo_q;
              we_d             = 1'b1;
            end
            default: begin
              rflags_d = flags_q;
              we_d     = 1'b0;
            end
          endcase
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= ADD16;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      lo_q     <= '0;
      c_lo_q   <= 1'b0;
      h_lo_q   <= 1'b0;
      result_q <= '0;
      rflags_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      flags_q  <= flags_d;
      lo_q     <= lo_d;
      c_lo_q   <= c_lo_d;
      h_lo_q   <= h_lo_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      we_q     <= we_d;
    end
  end

  assign resp_result  = result_q;
  assign resp_flags   = rflags_q;
  assign resp_flag_we = we_q;

endmodule

// File: tb/tb_gb_cpu_alu16_sequencer.sv
// Bench for gb_cpu_alu16_sequencer: a combinational-ALU instance (ALU_LAT=1) for
// directed and random ops, plus a registered-ALU instance (ALU_LAT=2) for latency.
module tb_gb_cpu_alu16_sequencer;
  import gb_cpu_common_pkg::*;

`ifdef GB_CPU_IDU_BYPASS_EN
  localparam bit IduBypass = 1'b1;
`else
  localparam bit IduBypass = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             req_valid, req_ready;
  alu16_op_t        req_op;
  logic [15:0]      req_a, req_b;
  logic [3:0]       req_flags;
  logic             resp_valid, resp_ready;
  logic [15:0]      resp_result;
  logic [3:0]       resp_flags;
  logic             resp_flag_we;
  logic             alu_req, alu_gnt;
  alu_instruction_t alu_instr;
  logic             alu_carry_in;
  logic [7:0]       alu_result;
  logic [3:0]       alu_flags;

  logic             req_valid2, req_ready2;
  logic             resp_valid2, resp_ready2;
  logic [15:0]      resp_result2;
  logic [3:0]       resp_flags2;
  logic             resp_flag_we2;
  logic             alu_req2, alu_gnt2;
  alu_instruction_t alu_instr2;
  logic             alu_carry_in2;
  logic [7:0]       alu_result2;
  logic [3:0]       alu_flags2;

  int checks = 0;
  int failures = 0;
  int alu_req_cycles = 0;
  int n2;

  gb_cpu_alu16_sequencer #(.ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_flag_we(resp_flag_we),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_instr(alu_instr),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  gb_cpu_alu16_sequencer #(.ALU_LAT(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_result(resp_result2),
    .resp_flags(resp_flags2), .resp_flag_we(resp_flag_we2),
    .alu_req(alu_req2), .alu_gnt(alu_gnt2), .alu_instr(alu_instr2),
    .alu_carry_in(alu_carry_in2), .alu_result(alu_result2), .alu_flags(alu_flags2)
  );

  // 8-bit ALU: returns {result, Z, N, H, C}
  function automatic logic [11:0] alu_model(input alu_instruction_t i, input logic cin);
    logic [8:0] s;
    logic [4:0] h;
    if (i.opcode == SUB) begin
      s = {1'b0, i.operand_a} - {1'b0, i.operand_b} - 9'(cin);
      h = {1'b0, i.operand_a[3:0]} - {1'b0, i.operand_b[3:0]} - 5'(cin);
      return {s[7:0], s[7:0] == 8'h00, 1'b1, h[4], s[8]};
    end
    s = {1'b0, i.operand_a} + {1'b0, i.operand_b} + 9'(cin);
    h = {1'b0, i.operand_a[3:0]} + {1'b0, i.operand_b[3:0]} + 5'(cin);
    return {s[7:0], s[7:0] == 8'h00, 1'b0, h[4], s[8]};
  endfunction

  assign {alu_result, alu_flags} = alu_model(alu_instr, alu_carry_in);

  always @(posedge clk) {alu_result2, alu_flags2} <= alu_model(alu_instr2, alu_carry_in2);

  always @(posedge clk) if (alu_req === 1'b1) alu_req_cycles <= alu_req_cycles + 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 16-bit reference computed directly from whole-word arithmetic
  task automatic model(input alu16_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fl, output logic [15:0] r, output logic [3:0] f,
                       output logic we);
    int unsigned ua, ub;
    int e;
    ua = a;
    ub = b;
    e  = $signed(b[7:0]);
    case (op)
      ADD16: begin
        r  = 16'(ua + ub);
        f  = {fl[3], 1'b0, ((ua & 32'hFFF) + (ub & 32'hFFF)) > 32'hFFF, (ua + ub) > 32'hFFFF};
        we = 1'b1;
      end
      ADD_SP_E8: begin
        r  = 16'(int'(ua) + e);
        f  = {2'b00, ((ua & 32'hF) + (ub & 32'hF)) > 32'hF, ((ua & 32'hFF) + (ub & 32'hFF)) > 32'hFF};
        we = 1'b1;
      end
      INC16: begin
        r  = 16'(ua + 1);
        f  = fl;
        we = 1'b0;
      end
      default: begin
        r  = 16'(ua + 32'hFFFF);
        f  = fl;
        we = 1'b0;
      end
    endcase
  endtask

  task automatic run_txn(input string tag, input alu16_op_t op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] fl, input int gnt_low,
                         input int rdy_low);
    logic [15:0]      er;
    logic [3:0]       ef;
    logic             ewe;
    int               n, exp_lat, exp_req, req0;
    alu_instruction_t instr0;
    logic             cin0;
    model(op, a, b, fl, er, ef, ewe);
    if (IduBypass && (op == INC16 || op == DEC16)) begin
      exp_lat = 1;
      exp_req = 0;
    end else begin
      exp_lat = 3 + gnt_low;
      exp_req = 2 + gnt_low;
    end
    @(negedge clk);
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_flags  = fl;
    resp_ready = (rdy_low == 0);
    alu_gnt    = (gnt_low == 0);
    @(posedge clk); #1;
    req0 = alu_req_cycles;
    chk({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    // Keep a different request offered while busy; it must not be latched
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_flags = 4'($urandom);
    n      = 1;
    instr0 = alu_instr;
    cin0   = alu_carry_in;
    while (resp_valid !== 1'b1 && n < 40) begin
      if (n > 1 && n <= gnt_low) begin
        chk({tag, ".instr_hold"}, 32'(alu_instr), 32'(instr0));
        chk({tag, ".cin_hold"}, 32'(alu_carry_in), 32'(cin0));
      end
      if (n == 2) req_valid = 1'b0;
      alu_gnt = (n > gnt_low);
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    alu_gnt   = 1'b1;
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".result"}, 32'(resp_result), 32'(er));
    chk({tag, ".flags"}, 32'(resp_flags), 32'(ef));
    chk({tag, ".flag_we"}, 32'(resp_flag_we), 32'(ewe));
    for (int k = 0; k < rdy_low; k++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_result"}, 32'(resp_result), 32'(er));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".alu_req_cycles"}, 32'(alu_req_cycles - req0), 32'(exp_req));
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = ADD16;
    req_a       = '0;
    req_b       = '0;
    req_flags   = '0;
    resp_ready  = 1'b1;
    alu_gnt     = 1'b1;
    req_valid2  = 1'b0;
    resp_ready2 = 1'b1;
    alu_gnt2    = 1'b1;
    #12;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.alu_req", 32'(alu_req), 32'd0);
    chk("rst.resp_result", 32'(resp_result), 32'd0);
    chk("rst.resp_flags", 32'(resp_flags), 32'd0);
    chk("rst.resp_flag_we", 32'(resp_flag_we), 32'd0);
    chk("rst.alu_instr", 32'(alu_instr), 32'd0);
    chk("rst.alu_carry_in", 32'(alu_carry_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_txn("add_h11", ADD16, 16'h0FFF, 16'h0001, 4'b1000, 0, 0);
    run_txn("add_wrap", ADD16, 16'hFFFF, 16'h0001, 4'b0000, 0, 0);
    run_txn("add_c15", ADD16, 16'h8000, 16'h8000, 4'b1111, 0, 0);
    run_txn("dec_wrap", DEC16, 16'h0000, 16'h1234, 4'b0101, 0, 0);
    run_txn("inc_carry", INC16, 16'h00FF, 16'hABCD, 4'b1010, 0, 0);
    run_txn("inc_wrap", INC16, 16'hFFFF, 16'h0000, 4'b0011, 0, 0);
    run_txn("sp_pos", ADD_SP_E8, 16'hFFF8, 16'h0008, 4'b1111, 0, 0);
    run_txn("sp_neg", ADD_SP_E8, 16'h0005, 16'h00FE, 4'b1111, 0, 0);
    run_txn("stall", ADD16, 16'h1234, 16'h0F0F, 4'b0000, 3, 2);

    for (int i = 0; i < 24; i++) begin
      run_txn($sformatf("rnd%0d", i), alu16_op_t'(2'($urandom_range(0, 3))), 16'($urandom),
              16'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)));
    end

    // Reset while in the high-byte pass aborts with no response
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ADD16;
    req_a     = 16'h0FFF;
    req_b     = 16'h0001;
    req_flags = 4'b1000;
    alu_gnt   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_hi.alu_req_before", 32'(alu_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_hi.req_ready", 32'(req_ready), 32'd1);
    chk("rst_hi.alu_req", 32'(alu_req), 32'd0);
    chk("rst_hi.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_hi.alu_instr", 32'(alu_instr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_hi.no_resp", 32'(resp_valid), 32'd0);
    chk("rst_hi.idle", 32'(req_ready), 32'd1);

    // Registered ALU: ADD16 case, grant dropped during the wait cycle
    @(negedge clk);
    req_op     = ADD16;
    req_a      = 16'h0FFF;
    req_b      = 16'h0001;
    req_flags  = 4'b1000;
    req_valid2 = 1'b1;
    chk("lat2.ready", 32'(req_ready2), 32'd1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    n2 = 1;
    while (resp_valid2 !== 1'b1 && n2 < 40) begin
      alu_gnt2 = (n2 != 2);
      @(posedge clk); #1;
      n2++;
    end
    alu_gnt2 = 1'b1;
    chk("lat2.latency", 32'(n2), 32'd5);
    chk("lat2.result", 32'(resp_result2), 32'h1000);
    chk("lat2.flags", 32'(resp_flags2), 32'b1010);
    chk("lat2.flag_we", 32'(resp_flag_we2), 32'd1);
    @(posedge clk); #1;
    chk("lat2.post_valid", 32'(resp_valid2), 32'd0);
    chk("lat2.post_alu_req", 32'(alu_req2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
